// File: rtl/rv_dbg_pkg.sv
// Shared types and constants for the run/debug sequencer of the RV32I core.
package rv_dbg_pkg;

  typedef enum logic [1:0] {
    StHold,
    StHalted,
    StRunning,
    StStepping
  } rc_state_t;

  typedef enum logic [1:0] {
    CmdHalt  = 2'b00,
    CmdRun   = 2'b01,
    CmdStep  = 2'b10,
    CmdSetBp = 2'b11
  } rc_cmd_t;

  typedef enum logic [2:0] {
    CauseReset      = 3'b000,
    CauseHost       = 3'b001,
    CauseBreakpoint = 3'b010,
    CauseEbreak     = 3'b011,
    CauseStepDone   = 3'b100
  } rc_cause_t;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/run_control_unit_if.sv
// Host command port of the run/debug sequencer: valid/ready handshake with opcode and argument.
interface run_control_unit_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/run_control_unit.sv
// Run/debug sequencer: gates the core's architectural updates via core_en, handles host
// HALT/RUN/STEP/SET_BP commands, stops on PC breakpoint or EBREAK and counts retirements.
module run_control_unit
  import rv_dbg_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned STEP_W        = 16,
  parameter int unsigned RST_HOLD      = 4,
  parameter bit          START_RUNNING = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  run_control_unit_if.slave  cmd,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        instr_i,
  output logic               core_en_o,
  output logic               halted_o,
  output logic [2:0]         halt_cause_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam int unsigned      HoldW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [HoldW-1:0] HoldOne  = 1;
  localparam logic [STEP_W-1:0] StepOne = 1;

  rc_state_t         state_q, state_d;
  rc_cause_t         cause_q, cause_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              skip_q, skip_d;
  logic              bp_en_q, bp_en_d;
  logic [31:0]       bp_addr_q, bp_addr_d;

  logic        accept;
  rc_cmd_t     op;
  logic        bp_hit;
  logic        ebreak_hit;
  logic        stop;
  logic        active;
  logic        core_en;
  logic [STEP_W-1:0] step_arg;
  logic        unused_arg;

  assign unused_arg = cmd.cmd_arg[1];

  assign cmd.cmd_ready = (state_q != StHold);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign op            = rc_cmd_t'(cmd.cmd_op);
  assign step_arg      = cmd.cmd_arg[STEP_W-1:0];

  // skip masks both stop sources for the first executed instruction after RUN/STEP.
  assign bp_hit     = bp_en_q && (pc_i == bp_addr_q);
  assign ebreak_hit = (instr_i == EBREAK_INSN);
  assign stop       = !skip_q && (bp_hit || ebreak_hit);
  assign active     = (state_q == StRunning) || (state_q == StStepping);
  assign core_en    = active && !stop;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    hold_cnt_d = hold_cnt_q;
    step_cnt_d = step_cnt_q;
    skip_d     = skip_q;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;

    if (core_en) begin
      skip_d = 1'b0;
    end

    if (accept && op == CmdSetBp) begin
      bp_addr_d = {cmd.cmd_arg[31:2], 2'b00};
      bp_en_d   = cmd.cmd_arg[0];
    end

    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = START_RUNNING ? StRunning : StHalted;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldOne;
        end
      end

      StHalted: begin
        if (accept && op == CmdRun) begin
          state_d = StRunning;
          skip_d  = 1'b1;
        end else if (accept && op == CmdStep) begin
          state_d    = StStepping;
          skip_d     = 1'b1;
          step_cnt_d = (step_arg == '0) ? StepOne : step_arg;
        end
      end

      StRunning, StStepping: begin
        if (stop) begin
          // The stopping instruction does not execute, so pc stays on it.
          state_d = StHalted;
          cause_d = bp_hit ? CauseBreakpoint : CauseEbreak;
        end else begin
          if (state_q == StStepping) begin
            step_cnt_d = step_cnt_q - StepOne;
          end
          if (accept && op == CmdRun) begin
            state_d = StRunning;
            skip_d  = 1'b1;
          end else if (accept && op == CmdHalt) begin
            state_d = StHalted;
            cause_d = CauseHost;
          end else if (state_q == StStepping && step_cnt_q == StepOne) begin
            state_d = StHalted;
            cause_d = CauseStepDone;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StHold;
      cause_q    <= CauseReset;
      hold_cnt_q <= '0;
      step_cnt_q <= '0;
      skip_q     <= 1'b0;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      hold_cnt_q <= hold_cnt_d;
      step_cnt_q <= step_cnt_d;
      skip_q     <= skip_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (core_en),
    .count_o (retired_o)
  );

  assign core_en_o    = core_en;
  assign halted_o     = (state_q == StHold) || (state_q == StHalted);
  assign halt_cause_o = cause_q;

endmodule

// File: tb/tb_run_control_unit.sv
// Bench for run_control_unit: a tiny core model (pc += 4 per core_en) plus a direct-drive
// vector table for the combinational stop/core_en path.
module tb_run_control_unit;
  import rv_dbg_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  run_control_unit_if cmd_if ();

  logic [31:0] pc, instr, pc_m, pc_v, instr_v, ebrk_addr;
  logic        use_m;
  logic        core_en, halted;
  logic [2:0]  cause;
  logic [31:0] retired;

  assign pc    = use_m ? pc_m : pc_v;
  assign instr = use_m ? ((pc_m == ebrk_addr) ? 32'h0010_0073 : 32'h0000_0013) : instr_v;

  run_control_unit #(
    .CNT_W         (32),
    .STEP_W        (16),
    .RST_HOLD      (4),
    .START_RUNNING (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd          (cmd_if),
    .pc_i         (pc),
    .instr_i      (instr),
    .core_en_o    (core_en),
    .halted_o     (halted),
    .halt_cause_o (cause),
    .retired_o    (retired)
  );

  // Core model: pc advances only when the sequencer lets the instruction retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_m <= 32'h0;
    else if (core_en) pc_m <= pc_m + 32'd4;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exp_en;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; command is presented across one posedge.
  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] target, input int budget, input string name);
    int n = 0;
    while (pc_m !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, pc_m, target);
  endtask

  task automatic wait_halt(input int budget, input string name);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, halted}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_core_en"}, {31'b0, core_en}, 32'd0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'd1);
    chk({tag, "_cause"}, {29'b0, cause}, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
    chk({tag, "_ready"}, {31'b0, cmd_if.cmd_ready}, 32'd0);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{32'h0000_0040, 32'h0000_0013, 1'b0};
    vecs[1] = '{32'h0000_0044, 32'h0000_0013, 1'b1};
    vecs[2] = '{32'h0000_0100, 32'h0010_0073, 1'b0};
    vecs[3] = '{32'h0000_0040, 32'h0010_0073, 1'b0};
    vecs[4] = '{32'h0000_0041, 32'h0000_0013, 1'b1};
    vecs[5] = '{32'h0000_0040, 32'h0000_0073, 1'b0};
    vecs[6] = '{32'h0000_0080, 32'h0000_0073, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0020_0073, 1'b1};

    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_arg   = 32'h0;
    use_m            = 1'b1;
    pc_v             = 32'h1000;
    instr_v          = 32'h13;
    ebrk_addr        = 32'h20;

    cyc(2);
    chk_reset("rst");

    // 1: four hold cycles after release, then running from pc 0
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold_en%0d", i), {31'b0, core_en}, 32'd0);
      @(negedge clk);
    end
    chk("run_en", {31'b0, core_en}, 32'd1);
    chk("run_halted", {31'b0, halted}, 32'd0);
    chk("run_retired0", retired, 32'd0);

    // 2: breakpoint at 0x10
    send(CmdSetBp, 32'h0000_0011);
    chk("retired1", retired, 32'd1);
    cyc(1);
    chk("retired2", retired, 32'd2);
    wait_pc(32'h10, 10, "reach_bp");
    chk("bp_stop_en", {31'b0, core_en}, 32'd0);
    cyc(1);
    chk("bp_halted", {31'b0, halted}, 32'd1);
    chk("bp_cause", {29'b0, cause}, 32'd2);
    chk("bp_pc", pc_m, 32'h10);
    chk("bp_retired", retired, 32'd4);

    // 3: step 3 from the breakpoint
    send(CmdStep, 32'd3);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (core_en) pulses++;
      @(negedge clk);
    end
    chk("step_pulses", pulses, 32'd3);
    chk("step_halted", {31'b0, halted}, 32'd1);
    chk("step_cause", {29'b0, cause}, 32'd4);
    chk("step_retired", retired, 32'd7);
    chk("step_pc", pc_m, 32'h1C);

    // 4: EBREAK at 0x20, then resume past it
    send(CmdRun, 32'd0);
    wait_halt(10, "ebreak_wait");
    chk("ebreak_cause", {29'b0, cause}, 32'd3);
    chk("ebreak_pc", pc_m, 32'h20);
    chk("ebreak_retired", retired, 32'd8);
    send(CmdRun, 32'd0);
    chk("ebreak_resume_en", {31'b0, core_en}, 32'd1);
    chk("ebreak_resume_pc", pc_m, 32'h20);
    send(CmdSetBp, 32'h0000_0041);
    chk("ebreak_past_pc", pc_m, 32'h24);
    chk("ebreak_past_ret", retired, 32'd9);

    // 5a: HALT arriving in the breakpoint cycle
    wait_pc(32'h40, 20, "reach_bp40");
    chk("bp40_en", {31'b0, core_en}, 32'd0);
    send(CmdHalt, 32'd0);
    chk("bphalt_halted", {31'b0, halted}, 32'd1);
    chk("bphalt_cause", {29'b0, cause}, 32'd2);
    chk("bphalt_pc", pc_m, 32'h40);
    chk("bphalt_retired", retired, 32'd16);

    // 5b: HALT alone retires the acceptance-cycle instruction
    send(CmdRun, 32'd0);
    cyc(1);
    chk("host_pre_pc", pc_m, 32'h44);
    send(CmdHalt, 32'd0);
    chk("host_halted", {31'b0, halted}, 32'd1);
    chk("host_cause", {29'b0, cause}, 32'd1);
    chk("host_pc", pc_m, 32'h48);
    chk("host_retired", retired, 32'd18);
    send(CmdHalt, 32'd0);
    chk("halt2_cause", {29'b0, cause}, 32'd1);
    chk("halt2_retired", retired, 32'd18);

    // Combinational stop table, bp at 0x40 enabled, skip already consumed
    use_m = 1'b0;
    send(CmdRun, 32'd0);
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      pc_v    = vecs[i].pc;
      instr_v = vecs[i].instr;
      #1;
      chk($sformatf("vec%0d_en", i), {31'b0, core_en}, {31'b0, vecs[i].exp_en});
      pc_v    = 32'h1000;
      instr_v = 32'h13;
      @(negedge clk);
    end

    // 6: async reset while stepping with step_cnt=5
    send(CmdHalt, 32'd0);
    chk("pre6_halted", {31'b0, halted}, 32'd1);
    send(CmdStep, 32'd5);
    chk("stepping_en", {31'b0, core_en}, 32'd1);
    chk("stepping_halted", {31'b0, halted}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    ebrk_addr = 32'hFFFF_FFF0;
    use_m     = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_pc(32'h40, 40, "post_rst_pc");
    chk("bp_cleared_en", {31'b0, core_en}, 32'd1);
    chk("bp_cleared_halted", {31'b0, halted}, 32'd0);
    chk("post_rst_retired", retired, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
